answer_tx: RTL and testbench
============================

Name: answer_tx

Overview:
- Transmit-side formatter for the puzzle datapath. Accepts one unsigned binary result word per handshake.
- Converts the word to decimal ASCII with leading zeros suppressed, followed by an end-of-line sequence.
- Feeds the characters one byte at a time into the UART transmitter's en/busy/data interface.
- Sits between the puzzle core's result output and the UART transmitter. It is the output counterpart of the receive-side byte stream.

Parameters:
- VALUE_W, 32, width of the binary result word.
- DIGITS, 10, BCD digit count; must be at least ceil(VALUE_W*log10(2)).
- EOL_CRLF, 1, 1 = emit 0x0D 0x0A after the digits; 0 = emit 0x0A only.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- resetn  input  1  synchronous active-low reset.
- value_data  input  VALUE_W  result word to print.
- value_valid  input  1  value_data is valid.
- value_ready  output  1  block can accept a word; transfer when value_valid && value_ready.
- tx_data  output  8  byte to the UART transmitter.
- tx_en  output  1  one-cycle pulse requesting transmission of tx_data.
- tx_busy  input  1  UART transmitter busy; rises the cycle after tx_en.

Behaviour:
- Interface rules:
  - One clock domain.
  - Reset is synchronous and active-low: sampled only on the clk rising edge when resetn==0.
- Reset values:
  - State is IDLE.
  - tx_en=0, tx_data=8'h00.
  - Internal shift, BCD, index and character counters are 0.
  - value_ready = (state==IDLE) && resetn, so it is 0 while resetn is low.
- States: IDLE, CONVERT, SKIP, SEND, GUARD, WAIT.
- IDLE:
  - value_ready=1.
  - On value_valid: latch value_data into the shift register, clear BCD, clear bit counter, go to CONVERT.
- CONVERT (double-dabble):
  - Each cycle, add 3 to every BCD nibble >=5, then shift {bcd,shift} left 1.
  - Exactly VALUE_W cycles.
  - Then set digit index = DIGITS-1 and go to SKIP.
- SKIP:
  - If nibble[index]==0 and index!=0: decrement index, stay (one nibble per cycle).
  - Otherwise go to SEND. Value 0 therefore prints the single digit "0".
- Character sequence: digits from index down to 0 (0x30+nibble), then EOL bytes.
- SEND:
  - If tx_busy==0: drive tx_en=1 for exactly one cycle with tx_data = current character (registered), go to GUARD.
  - If tx_busy==1: hold, tx_en=0.
- GUARD: one cycle; tx_busy is ignored; tx_en=0. Go to WAIT.
- WAIT:
  - When tx_busy==0: advance the character pointer.
  - If characters remain, go to SEND; else go to IDLE.
- tx_data holds its last value between pulses.
- tx_en is never asserted in two consecutive cycles, and never while tx_busy==1.
- Latency, from the accept edge to the first tx_en, is 1 + VALUE_W + (number of leading-zero nibbles skipped) + 1 cycles when tx_busy==0.
  - Value 0 with default parameters: 1+32+9+1 = 43 cycles.
- value_valid while not in IDLE is ignored: value_ready=0 and no word is latched.
- value_valid in the same cycle the FSM returns to IDLE is not accepted. Acceptance is possible from the next cycle.
- Reset mid-operation:
  - Next cycle is IDLE with all reset values; the partially sent line is abandoned.
  - An in-flight UART byte is the transmitter's concern.
- Arithmetic:
  - All BCD nibble adds are 4-bit with no carry out, because the +3 rule keeps nibbles ≤ 12 before the shift.
  - Input is unsigned; the full VALUE_W range is supported.

Test Plan:
- Bench UART model: raises tx_busy the cycle after tx_en and holds it 20 cycles.
- Value 0 -> bytes 0x30 0x0D 0x0A.
  - Exactly 3 tx_en pulses.
  - First pulse 43 cycles after accept.
  - value_ready returns 1 after the last busy falls.
- Value 1234 -> bytes "1234" then 0x0D 0x0A; 6 pulses, each one cycle wide, none while tx_busy=1.
- Value 32'hFFFFFFFF -> "4294967295\r\n", 12 bytes; no leading zero skipping.
- Two words presented back-to-back with value_valid held high:
  - The second is accepted only after the first line completes.
  - Output is the two lines in order; no byte lost or duplicated.
- Hold tx_busy=1 externally for 100 cycles while in SEND -> tx_en stays 0 throughout, then the byte goes out 1 cycle after busy falls.
- Assert resetn=0 for 1 cycle after the 2nd byte of "1234":
  - tx_en=0 and value_ready=0 during reset, then 1 in IDLE.
  - No further bytes of the old line.
  - A new value 7 prints "7\r\n".
  - With EOL_CRLF=0, value 7 prints 0x37 0x0A.

Source files
------------

// File: rtl/answer_tx.sv
// Binary result word -> decimal ASCII line (leading zeros suppressed, EOL appended),
// streamed one byte at a time into a UART transmitter's en/busy/data port.
module answer_tx #(
  parameter int VALUE_W  = 32,
  parameter int DIGITS   = 10,
  parameter bit EOL_CRLF = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [VALUE_W-1:0] value_data,
  input  logic               value_valid,
  output logic               value_ready,
  output logic [7:0]         tx_data,
  output logic               tx_en,
  input  logic               tx_busy
);
  localparam int         BIT_W    = $clog2(VALUE_W + 1);
  localparam int         IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [1:0] EOL_LAST = EOL_CRLF ? 2'd2 : 2'd1;

  typedef enum logic [2:0] {S_IDLE, S_CONVERT, S_SKIP, S_SEND, S_GUARD, S_WAIT} state_t;
  state_t r_state, w_next;

  logic [VALUE_W-1:0]  r_shift;
  logic [4*DIGITS-1:0] r_bcd;
  logic [BIT_W-1:0]    r_bit;
  logic [IDX_W-1:0]    r_idx;
  logic [1:0]          r_eol;  // 0 while sending digits, then 1..EOL_LAST per EOL byte
  logic [7:0]          r_tx_data;
  logic                r_tx_en;

  logic [4*DIGITS-1:0] w_bcd_adj;
  logic [3:0]          w_nib;
  logic [7:0]          w_char;
  logic                w_conv_done;
  logic                w_last_char;
  logic                w_skip;

  // Double-dabble correction; nibbles never exceed 12 here, so 4-bit adds suffice.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dabble
    assign w_bcd_adj[4*g +: 4] = (r_bcd[4*g +: 4] >= 4'd5) ? r_bcd[4*g +: 4] + 4'd3
                                                           : r_bcd[4*g +: 4];
  end

  assign w_nib       = r_bcd[4*int'(r_idx) +: 4];
  assign w_conv_done = (r_bit == BIT_W'(VALUE_W - 1));
  assign w_last_char = (r_eol == EOL_LAST);
  assign w_skip      = (w_nib == 4'd0) && (r_idx != '0);

  always_comb begin
    w_char = 8'h0A;
    if (r_eol == 2'd0)                   w_char = {4'h3, w_nib};
    else if (EOL_CRLF && r_eol == 2'd1)  w_char = 8'h0D;
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (value_valid) w_next = S_CONVERT;
      S_CONVERT: if (w_conv_done) w_next = S_SKIP;
      S_SKIP:    if (!w_skip)     w_next = S_SEND;
      S_SEND:    if (!tx_busy)    w_next = S_GUARD;
      // busy only rises the cycle after tx_en, so GUARD skips that stale sample
      S_GUARD:   w_next = S_WAIT;
      S_WAIT:    if (!tx_busy)    w_next = w_last_char ? S_IDLE : S_SEND;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_shift   <= '0;
      r_bcd     <= '0;
      r_bit     <= '0;
      r_idx     <= '0;
      r_eol     <= '0;
      r_tx_data <= 8'h00;
      r_tx_en   <= 1'b0;
    end else begin
      r_tx_en <= 1'b0;
      case (r_state)
        S_IDLE: if (value_valid) begin
          r_shift <= value_data;
          r_bcd   <= '0;
          r_bit   <= '0;
          r_eol   <= '0;
        end
        S_CONVERT: begin
          {r_bcd, r_shift} <= {w_bcd_adj, r_shift} << 1;
          r_bit            <= r_bit + 1'b1;
          if (w_conv_done) r_idx <= IDX_W'(DIGITS - 1);
        end
        S_SKIP: if (w_skip) r_idx <= r_idx - 1'b1;
        S_SEND: if (!tx_busy) begin
          r_tx_en   <= 1'b1;
          r_tx_data <= w_char;
        end
        S_WAIT: if (!tx_busy) begin
          if (r_eol == 2'd0 && r_idx != '0) r_idx <= r_idx - 1'b1;
          else if (!w_last_char)            r_eol <= r_eol + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign value_ready = (r_state == S_IDLE) && resetn;
  assign tx_en       = r_tx_en;
  assign tx_data     = r_tx_data;
endmodule

// File: tb/tb_answer_tx.sv
// Scoreboard bench for answer_tx: expected bytes queued at issue time, popped by a
// monitor on every tx_en pulse; a UART model holds busy for 20 cycles per byte.
module tb_answer_tx;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [31:0] value_data;
  logic        value_valid, value_ready;
  logic [7:0]  tx_data;
  logic        tx_en, tx_busy;
  logic        ext_hold;
  int          bcnt = 0;

  logic [31:0] lf_data;
  logic        lf_valid, lf_ready;
  logic [7:0]  lf_tx_data;
  logic        lf_tx_en, lf_tx_busy;
  int          lf_bcnt = 0;

  int          n_cmp = 0, n_bad = 0, pulses = 0, lf_pulses = 0;
  logic        prev_en = 1'b0, lf_prev_en = 1'b0;
  logic [7:0]  q[$];
  logic [7:0]  q_lf[$];

  answer_tx #(.VALUE_W(32), .DIGITS(10), .EOL_CRLF(1'b1)) dut (
    .clk(clk), .resetn(resetn), .value_data(value_data), .value_valid(value_valid),
    .value_ready(value_ready), .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy));

  answer_tx #(.VALUE_W(32), .DIGITS(10), .EOL_CRLF(1'b0)) dut_lf (
    .clk(clk), .resetn(resetn), .value_data(lf_data), .value_valid(lf_valid),
    .value_ready(lf_ready), .tx_data(lf_tx_data), .tx_en(lf_tx_en), .tx_busy(lf_tx_busy));

  // UART model: busy rises the cycle after tx_en and stays up 20 cycles
  assign tx_busy    = (bcnt != 0) || ext_hold;
  assign lf_tx_busy = (lf_bcnt != 0);
  always @(posedge clk) begin
    if (tx_en)             bcnt <= 20;
    else if (bcnt != 0)    bcnt <= bcnt - 1;
    if (lf_tx_en)          lf_bcnt <= 20;
    else if (lf_bcnt != 0) lf_bcnt <= lf_bcnt - 1;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic expect_line(input string s);
    for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
    q.push_back(8'h0D);
    q.push_back(8'h0A);
  endtask

  // Monitors: pop and compare on each tx_en pulse
  always @(negedge clk) begin
    if (tx_en) begin
      pulses++;
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL byte: got 0x%02h expected no byte", tx_data);
      end else check("byte", tx_data, q.pop_front());
      check("pulse_rule(prev_en,busy)", {prev_en, tx_busy}, 0);
    end
    prev_en = tx_en;
  end

  always @(negedge clk) begin
    if (lf_tx_en) begin
      lf_pulses++;
      if (q_lf.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL lf_byte: got 0x%02h expected no byte", lf_tx_data);
      end else check("lf_byte", lf_tx_data, q_lf.pop_front());
      check("lf_pulse_rule(prev_en,busy)", {lf_prev_en, lf_tx_busy}, 0);
    end
    lf_prev_en = lf_tx_en;
  end

  // Present a word; returns on the negedge after the accepting edge, valid still high
  task automatic offer(input logic [31:0] v);
    int k = 0;
    @(negedge clk);
    value_data  = v;
    value_valid = 1'b1;
    while (!value_ready && k < 2000) begin @(negedge clk); k++; end
    if (k >= 2000) flag("accept");
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_first(output int k);
    k = 0;
    while (!tx_en && k < 500) begin @(negedge clk); k++; end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!value_ready && k < 2000) begin @(negedge clk); k++; end
    if (k >= 2000) flag("idle");
    else begin
      check("idle_busy", tx_busy, 0);
      check("idle_queue_left", q.size(), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, p1, k, bad;
    resetn = 1'b0; value_valid = 1'b0; value_data = '0; ext_hold = 1'b0;
    lf_valid = 1'b0; lf_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", value_ready, 0);
    check("rst_en", tx_en, 0);
    check("rst_data", tx_data, 8'h00);
    resetn = 1'b1;
    #1 check("ready_after_rst", value_ready, 1);

    // value 0: "0\r\n", 9 leading zeros skipped
    p0 = pulses; expect_line("0");
    offer(32'd0); value_valid = 1'b0;
    wait_first(k); check("latency_0", k, 43);
    wait_idle(); check("pulses_0", pulses - p0, 3);

    p0 = pulses; expect_line("1234");
    offer(32'd1234); value_valid = 1'b0;
    wait_first(k); check("latency_1234", k, 40);
    wait_idle(); check("pulses_1234", pulses - p0, 6);

    p0 = pulses; expect_line("4294967295");
    offer(32'hFFFF_FFFF); value_valid = 1'b0;
    wait_first(k); check("latency_max", k, 34);
    wait_idle(); check("pulses_max", pulses - p0, 12);

    // back-to-back with valid held: second word waits for the first line
    p0 = pulses; expect_line("5"); expect_line("86");
    offer(32'd5); value_data = 32'd86;
    k = 0;
    while (!value_ready && k < 2000) begin @(negedge clk); k++; end
    if (k >= 2000) flag("b2b_accept");
    check("b2b_pending_at_accept", q.size(), 4);
    @(posedge clk); @(negedge clk); value_valid = 1'b0;
    wait_idle(); check("pulses_b2b", pulses - p0, 7);

    // external busy held well past SEND entry
    p0 = pulses; expect_line("9");
    offer(32'd9); value_valid = 1'b0; ext_hold = 1'b1;
    bad = 0;
    repeat (150) begin @(negedge clk); if (tx_en) bad++; end
    check("hold_no_en", bad, 0);
    ext_hold = 1'b0;
    wait_first(k); check("hold_release_lat", k, 1);
    wait_idle(); check("pulses_hold", pulses - p0, 3);

    // reset after the second byte of "1234"
    p0 = pulses; expect_line("1234");
    offer(32'd1234); value_valid = 1'b0;
    k = 0;
    while (pulses - p0 < 2 && k < 2000) begin @(negedge clk); #1; k++; end
    if (k >= 2000) flag("midrst_second_byte");
    @(negedge clk);
    resetn = 1'b0;
    q.delete();
    #1 check("midrst_ready_low", value_ready, 0);
    @(negedge clk);
    check("midrst_en", tx_en, 0);
    check("midrst_data", tx_data, 8'h00);
    check("midrst_ready_still_low", value_ready, 0);
    resetn = 1'b1;
    #1 check("midrst_ready_idle", value_ready, 1);
    p1 = pulses;
    repeat (80) @(negedge clk);
    check("midrst_no_stale_bytes", pulses - p1, 0);
    p0 = pulses; expect_line("7");
    offer(32'd7); value_valid = 1'b0;
    wait_idle(); check("pulses_7", pulses - p0, 3);

    // LF-only variant
    p0 = lf_pulses;
    q_lf.push_back(8'h37); q_lf.push_back(8'h0A);
    @(negedge clk); lf_data = 32'd7; lf_valid = 1'b1;
    k = 0;
    while (!lf_ready && k < 2000) begin @(negedge clk); k++; end
    if (k >= 2000) flag("lf_accept");
    @(posedge clk); @(negedge clk); lf_valid = 1'b0;
    k = 0;
    while (!lf_ready && k < 2000) begin @(negedge clk); k++; end
    if (k >= 2000) flag("lf_idle");
    check("lf_pulses", lf_pulses - p0, 2);
    check("lf_queue_left", q_lf.size(), 0);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
